// File: rtl/ow_slave_ds1821.sv
// DS1821-subset 1-wire responder: reset/presence handling, LSB-first command
// reception, temperature/status read-back and start/stop-convert tracking.
module ow_slave_ds1821 #(
    parameter int TICKS_PER_US     = 50,
    parameter int RESET_MIN_US     = 400,
    parameter int PRESENCE_WAIT_US = 30,
    parameter int PRESENCE_LEN_US  = 120,
    parameter int SAMPLE_US        = 30,
    parameter int TX_LOW_US        = 45
) (
    input  logic       ow_clk,
    input  logic       ow_reset,
    input  logic       ow_bus_in,
    output logic       ow_pull_low,
    input  logic [7:0] temp_in,
    output logic [7:0] status_out,
    output logic       conv_active,
    output logic       cmd_strobe,
    output logic [7:0] cmd_code
);

    localparam logic [19:0] RESET_TICKS = 20'(RESET_MIN_US * TICKS_PER_US);
    localparam logic [19:0] PWAIT_LAST  = 20'(PRESENCE_WAIT_US * TICKS_PER_US - 1);
    localparam logic [19:0] PLEN_LAST   = 20'(PRESENCE_LEN_US * TICKS_PER_US - 1);
    localparam logic [19:0] SAMPLE_LAST = 20'(SAMPLE_US * TICKS_PER_US - 1);
    localparam logic [19:0] TXLOW_LAST  = 20'(TX_LOW_US * TICKS_PER_US - 1);
    localparam logic [19:0] TIMER_MAX   = 20'hFFFFF;

    localparam logic [7:0] CMD_READ_TEMP  = 8'hAA;
    localparam logic [7:0] CMD_READ_STAT  = 8'hAC;
    localparam logic [7:0] CMD_START_CONV = 8'hEE;
    localparam logic [7:0] CMD_STOP_CONV  = 8'h22;
    localparam logic [7:0] CMD_WRITE_STAT = 8'h0C;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRES_WAIT,
        S_PRES_DRIVE,
        S_RX_CMD,
        S_DECODE,
        S_RX_DATA,
        S_TX_DATA
    } state_t;

    // Saturating increment shared by the low timer and the slot timer.
    function automatic logic [19:0] sat_inc(input logic [19:0] v, input logic [19:0] lim);
        return (v >= lim) ? lim : v + 20'd1;
    endfunction

    logic        bus_meta_q, bus_s_q, bus_prev_q;
    logic [19:0] low_cnt_q, low_cnt_d;
    logic [19:0] slot_q;
    state_t      state_q;
    logic [2:0]  bit_q;
    logic        armed_q;
    logic [7:0]  shreg_q, shreg_d;
    logic [7:0]  txbuf_q;
    logic        pull_q;
    logic [7:0]  status_q;
    logic        conv_q;
    logic        strobe_q;
    logic [7:0]  code_q;
    logic        fall, rise, bus_reset;

    assign ow_pull_low = pull_q;
    assign status_out  = status_q;
    assign conv_active = conv_q;
    assign cmd_strobe  = strobe_q;
    assign cmd_code    = code_q;

    // Bring the asynchronous line into the clock domain and keep a delayed copy for edges.
    always_ff @(posedge ow_clk) begin
        if (ow_reset) begin
            bus_meta_q <= 1'b1;
            bus_s_q    <= 1'b1;
            bus_prev_q <= 1'b1;
        end else begin
            bus_meta_q <= ow_bus_in;
            bus_s_q    <= bus_meta_q;
            bus_prev_q <= bus_s_q;
        end
    end

    // Edge detection, bus-reset qualification and next-bit shift value.
    always_comb begin
        // Falls while we hold the line ourselves are our own echo, not the master.
        fall      = bus_prev_q & ~bus_s_q & ~pull_q;
        rise      = ~bus_prev_q & bus_s_q;
        bus_reset = rise && (low_cnt_q == RESET_TICKS);
        low_cnt_d = bus_s_q ? 20'd0 : sat_inc(low_cnt_q, RESET_TICKS);
        shreg_d   = shreg_q;
        shreg_d[bit_q] = bus_s_q;
    end

    // Measure how long the line has been low so long lows can be told from slots.
    always_ff @(posedge ow_clk) begin
        if (ow_reset) begin
            low_cnt_q <= 20'd0;
        end else begin
            low_cnt_q <= low_cnt_d;
        end
    end

    // Protocol state machine with registered line driver and outputs.
    always_ff @(posedge ow_clk) begin
        if (ow_reset) begin
            state_q  <= S_IDLE;
            slot_q   <= 20'd0;
            bit_q    <= 3'd0;
            armed_q  <= 1'b0;
            pull_q   <= 1'b0;
            status_q <= 8'h00;
            conv_q   <= 1'b0;
            strobe_q <= 1'b0;
            code_q   <= 8'h00;
        end else begin
            strobe_q <= 1'b0;
            slot_q   <= fall ? 20'd0 : sat_inc(slot_q, TIMER_MAX);
            if (bus_reset) begin
                // A master reset wins over anything in progress, including a presence pulse.
                state_q <= S_PRES_WAIT;
                slot_q  <= 20'd0;
                pull_q  <= 1'b0;
                bit_q   <= 3'd0;
                armed_q <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                    end
                    S_PRES_WAIT: begin
                        if (slot_q == PWAIT_LAST) begin
                            state_q <= S_PRES_DRIVE;
                            slot_q  <= 20'd0;
                            pull_q  <= 1'b1;
                        end
                    end
                    S_PRES_DRIVE: begin
                        if (slot_q == PLEN_LAST) begin
                            state_q <= S_RX_CMD;
                            pull_q  <= 1'b0;
                            bit_q   <= 3'd0;
                            armed_q <= 1'b0;
                        end
                    end
                    S_RX_CMD, S_RX_DATA: begin
                        if (fall) begin
                            armed_q <= 1'b1;
                        end else if (armed_q && slot_q == SAMPLE_LAST) begin
                            armed_q <= 1'b0;
                            shreg_q <= shreg_d;
                            if (bit_q == 3'd7) begin
                                bit_q <= 3'd0;
                                if (state_q == S_RX_CMD) begin
                                    code_q   <= shreg_d;
                                    strobe_q <= 1'b1;
                                    state_q  <= S_DECODE;
                                end else begin
                                    status_q <= shreg_d;
                                    state_q  <= S_IDLE;
                                end
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end
                    end
                    S_DECODE: begin
                        bit_q   <= 3'd0;
                        armed_q <= 1'b0;
                        case (code_q)
                            CMD_READ_TEMP: begin
                                txbuf_q <= temp_in;
                                state_q <= S_TX_DATA;
                            end
                            CMD_READ_STAT: begin
                                txbuf_q <= status_q;
                                state_q <= S_TX_DATA;
                            end
                            CMD_START_CONV: begin
                                conv_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end
                            CMD_STOP_CONV: begin
                                conv_q  <= 1'b0;
                                state_q <= S_IDLE;
                            end
                            CMD_WRITE_STAT: state_q <= S_RX_DATA;
                            default:        state_q <= S_IDLE;
                        endcase
                    end
                    S_TX_DATA: begin
                        if (fall) begin
                            armed_q <= 1'b1;
                            pull_q  <= ~txbuf_q[bit_q];
                        end else if (armed_q && slot_q == TXLOW_LAST) begin
                            // 0 bits release here; 1 bits advance at the same count.
                            armed_q <= 1'b0;
                            pull_q  <= 1'b0;
                            if (bit_q == 3'd7) begin
                                bit_q   <= 3'd0;
                                state_q <= S_IDLE;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                            end
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ow_slave_ds1821.sv
// Directed bench for ow_slave_ds1821 acting as the 1-wire master on a wired-AND line.
module tb_ow_slave_ds1821;

    localparam int TK = 2;              // ticks per microsecond for a short run
    localparam int PW = 30 * TK;        // presence wait in cycles
    localparam int PL = 120 * TK;       // presence length in cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       master_low = 1'b0;
    logic [7:0] temp = 8'h00;
    logic       pull;
    logic [7:0] status;
    logic       conv;
    logic       strobe;
    logic [7:0] code;

    wire bus_line = ~(master_low | pull);

    int n_tests = 0;
    int n_fail  = 0;
    int strobes = 0;
    logic [7:0] last_code = 8'h00;

    always #5 clk = ~clk;

    ow_slave_ds1821 #(.TICKS_PER_US(TK)) dut (
        .ow_clk     (clk),
        .ow_reset   (rst),
        .ow_bus_in  (bus_line),
        .ow_pull_low(pull),
        .temp_in    (temp),
        .status_out (status),
        .conv_active(conv),
        .cmd_strobe (strobe),
        .cmd_code   (code)
    );

    // Count strobe-high cycles and remember the code seen with each.
    always @(negedge clk) begin
        if (strobe) begin
            strobes   = strobes + 1;
            last_code = code;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_bit(input logic b);
        master_low = 1'b1;
        if (b) begin
            cyc(6 * TK);
            master_low = 1'b0;
            cyc(64 * TK);
        end else begin
            cyc(60 * TK);
            master_low = 1'b0;
            cyc(10 * TK);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) write_bit(b[i]);
    endtask

    task automatic read_byte(output logic [7:0] b, input int change_at, input logic [7:0] new_temp);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            master_low = 1'b1;
            cyc(2 * TK);
            master_low = 1'b0;
            cyc(13 * TK);
            b[i] = bus_line;
            cyc(55 * TK);
            if (i == change_at) temp = new_temp;
        end
    endtask

    task automatic reset_pres();
        master_low = 1'b1;
        cyc(480 * TK);
        master_low = 1'b0;
        cyc(300 * TK);
    endtask

    initial begin
        int cnt;
        int s0;
        logic seen;
        logic [7:0] rb;

        cyc(3);
        chk("rst_pull", pull, 1'b0);
        chk("rst_status", status, 8'h00);
        chk("rst_conv", conv, 1'b0);
        chk("rst_strobe", strobe, 1'b0);
        chk("rst_code", code, 8'h00);
        rst = 1'b0;
        cyc(2);

        // Presence: delay from release and exact pulse width.
        master_low = 1'b1;
        cyc(480 * TK);
        master_low = 1'b0;
        cnt = 0;
        while (!pull && cnt < PW + 50) begin
            cyc(1);
            cnt++;
        end
        chk("pres_delay_in_window", (cnt >= PW - 3 && cnt <= PW + 3), 1'b1);
        cnt = 0;
        while (pull && cnt < PL + 50) begin
            cyc(1);
            cnt++;
        end
        chk("pres_width", cnt, PL);
        chk("pres_no_strobe", strobes, 0);

        // Short low is not a reset; slots in IDLE do nothing.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        master_low = 1'b1;
        cyc(300 * TK);
        master_low = 1'b0;
        seen = 1'b0;
        repeat (300 * TK) begin
            cyc(1);
            if (pull) seen = 1'b1;
        end
        chk("short_low_no_pres", seen, 1'b0);
        write_byte(8'hEE);
        cyc(10);
        chk("idle_ignores_conv", conv, 1'b0);
        chk("idle_ignores_strobe", strobes, 0);

        // START_CONVERT, unknown command, STOP_CONVERT.
        reset_pres();
        s0 = strobes;
        write_byte(8'hEE);
        cyc(10);
        chk("ee_strobe_cycles", strobes - s0, 1);
        chk("ee_code", last_code, 8'hEE);
        chk("ee_conv", conv, 1'b1);
        reset_pres();
        write_byte(8'h55);
        cyc(10);
        chk("unk_code", code, 8'h55);
        chk("unk_conv_kept", conv, 1'b1);
        reset_pres();
        write_byte(8'h22);
        cyc(10);
        chk("22_code", code, 8'h22);
        chk("22_conv", conv, 1'b0);

        // READ_TEMP with temp_in changing mid-read.
        temp = 8'h19;
        reset_pres();
        write_byte(8'hAA);
        read_byte(rb, 3, 8'hE7);
        chk("read_temp", rb, 8'h19);

        // WRITE_STATUS then READ_STATUS.
        reset_pres();
        s0 = strobes;
        write_byte(8'h0C);
        write_byte(8'h5A);
        cyc(10);
        chk("wstat_status", status, 8'h5A);
        chk("wstat_one_strobe", strobes - s0, 1);
        chk("wstat_code", last_code, 8'h0C);
        reset_pres();
        write_byte(8'hAC);
        read_byte(rb, -1, 8'h00);
        chk("read_status", rb, 8'h5A);

        // Bus reset after three command bits.
        reset_pres();
        s0 = strobes;
        write_bit(1'b0);
        write_bit(1'b1);
        write_bit(1'b1);
        master_low = 1'b1;
        cyc(480 * TK);
        master_low = 1'b0;
        cnt = 0;
        while (!pull && cnt < PW + 50) begin
            cyc(1);
            cnt++;
        end
        chk("abort_pres", pull, 1'b1);
        chk("abort_no_strobe", strobes - s0, 0);
        cyc(200 * TK);
        write_byte(8'hEE);
        cyc(10);
        chk("abort_then_ee_code", code, 8'hEE);
        chk("abort_then_ee_conv", conv, 1'b1);

        // ow_reset while driving a 0 bit.
        temp = 8'h00;
        reset_pres();
        write_byte(8'hAA);
        master_low = 1'b1;
        cyc(2 * TK);
        master_low = 1'b0;
        cyc(10 * TK);
        chk("tx_drive_low", pull, 1'b1);
        rst = 1'b1;
        cyc(1);
        chk("orst_pull", pull, 1'b0);
        chk("orst_status", status, 8'h00);
        chk("orst_conv", conv, 1'b0);
        chk("orst_code", code, 8'h00);
        rst = 1'b0;
        cyc(5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
